// File: rtl/branch_pkg.sv
// Shared types for the branch unit: condition encoding, 2-bit counter states
// and the saturating counter update helpers.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGTZ = 3'd3,
    BR_BLTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == ST) ? ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator; all magnitude tests treat rs as
// a WIDTH-bit two's complement value, rt only matters for BEQ/BNE.
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  br_op_t           br_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             cond_true
);

  localparam logic signed [WIDTH-1:0] ZERO = '0;

  logic signed [WIDTH-1:0] rs_s;
  assign rs_s = rs_val;

  always_comb begin
    cond_true = 1'b0;
    case (br_op)
      BR_BEQ:  cond_true = (rs_val == rt_val);
      BR_BNE:  cond_true = (rs_val != rt_val);
      BR_BGTZ: cond_true = (rs_s >  ZERO);
      BR_BLTZ: cond_true = (rs_s <  ZERO);
      BR_BLEZ: cond_true = (rs_s <= ZERO);
      BR_BGEZ: cond_true = (rs_s >= ZERO);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// PC-indexed 2-bit counter predictor with decode-stage branch resolution.
// Optional BRANCH_STATS_EN adds branch_cnt / mispred_cnt statistics outputs.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int INDEX_LSB = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_f,
  output logic             pred_taken_f,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             pred_taken_d,
  input  logic             stall,
  output logic             taken,
  output logic             mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  br_op_t           op;
  logic             cond_true;
  logic             is_branch;
  logic             upd;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_r;
  logic [1:0]       bht_q [BHT_DEPTH];
  logic [1:0]       bht_d [BHT_DEPTH];

  assign op = br_op_t'(br_op);

  branch_cond #(
    .WIDTH(WIDTH)
  ) u_cond (
    .br_op    (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .cond_true(cond_true)
  );

  assign is_branch = (op != BR_NONE) && (op != BR_RSVD);
  assign upd       = res_valid & ~stall & is_branch;

  assign taken      = upd & cond_true;
  assign mispredict = upd & (cond_true != pred_taken_d);

  // No tags: any PCs sharing these bits share one counter.
  assign idx_f = pc_f[INDEX_LSB +: IDX_W];
  assign idx_r = res_pc[INDEX_LSB +: IDX_W];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign pred_taken_f = bht_q[idx_f][1];

  always_comb begin
    bht_d = bht_q;
    if (upd) begin
      bht_d[idx_r] = cond_true ? ctr_inc(bht_q[idx_r]) : ctr_dec(bht_q[idx_r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= WNT;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (upd) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
      if (mispredict) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule
